reg_seq_ctrl: RTL and testbench

REG_SEQ_CTRL -- requirements
Module: reg_seq_ctrl

---
 rtl/reg_seq_ctrl.sv | 89 ++++++++
 tb/tb_reg_seq_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/reg_seq_ctrl.sv
// reg_seq_ctrl: four-state multi-cycle sequencer driving a 4x8 register file (read, execute, write back)
module reg_seq_ctrl #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [7:0]       instr,
  input  logic             instr_valid,
  output logic             instr_ready,
  output logic [1:0]       ReadReg1,
  output logic [1:0]       ReadReg2,
  input  logic [7:0]       ReadData1,
  input  logic [7:0]       ReadData2,
  output logic [1:0]       WriteReg,
  output logic [7:0]       WriteData,
  output logic             RegWrite,
  output logic             done,
  output logic             ovf,
  output logic [CNT_W-1:0] retired
);
  typedef enum logic [1:0] {IDLE, READ, EXEC, WB} state_t;
  state_t r_state, w_next;
  logic [5:0] r_instr;
  logic [7:0] r_a, r_b;
  logic       r_ovf;
  logic [1:0] w_op;
  logic [7:0] w_opb, w_sum, w_res;
  logic [1:0] w_dest;
  logic       w_ovf;
  // state register; reset aborts any in-flight instruction
  always_ff @(posedge clk or posedge reset)
    if (reset) r_state <= IDLE;
    else r_state <= w_next;
  // next state: only IDLE waits, every other state advances unconditionally
  always_comb
    w_next = r_state == IDLE ? (instr_valid ? READ : IDLE) :
             r_state == READ ? EXEC :
             r_state == EXEC ? WB : IDLE;
  // state-decoded handshake and write strobe
  always_comb begin
    instr_ready = r_state == IDLE;
    RegWrite    = r_state == WB;
  end
  // execute: SUB reuses the adder as A + ~B + 1, ADDI feeds the sign-extended immediate
  always_comb begin
    w_op   = r_instr[5:4];
    w_opb  = w_op == 2'b10 ? {{6{r_instr[1]}}, r_instr[1:0]} : w_op == 2'b01 ? ~r_b : r_b;
    w_sum  = r_a + w_opb + {7'd0, w_op == 2'b01};
    w_res  = w_op == 2'b11 ? (r_a & r_b) : w_sum;
    w_ovf  = w_op != 2'b11 && r_a[7] == w_opb[7] && w_sum[7] != r_a[7];
    w_dest = w_op == 2'b10 ? r_instr[3:2] : r_instr[1:0];
  end
  // datapath: capture, operand latch, result latch, and retirement bookkeeping
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      r_instr   <= '0;
      ReadReg1  <= '0;
      ReadReg2  <= '0;
      r_a       <= '0;
      r_b       <= '0;
      WriteReg  <= '0;
      WriteData <= '0;
      r_ovf     <= 1'b0;
      done      <= 1'b0;
      ovf       <= 1'b0;
      retired   <= '0;
    end else begin
      done <= 1'b0;
      if (r_state == IDLE && instr_valid) begin
        r_instr  <= {instr[7:6], instr[3:0]};
        ReadReg1 <= instr[5:4];
        ReadReg2 <= instr[3:2];
      end
      if (r_state == READ) begin
        r_a <= ReadData1;
        r_b <= ReadData2;
      end
      if (r_state == EXEC) begin
        WriteReg  <= w_dest;
        WriteData <= w_res;
        r_ovf     <= w_ovf;
      end
      if (r_state == WB) begin
        done    <= 1'b1;
        ovf     <= r_ovf;
        retired <= retired + 1'b1;
      end
    end
endmodule

// File: tb/tb_reg_seq_ctrl.sv
// tb_reg_seq_ctrl: scoreboard bench with a behavioural register file and reference model
module tb_reg_seq_ctrl;
  logic       clk = 0, reset = 1, instr_valid = 0;
  logic [7:0] instr = 0;
  logic       instr_ready, RegWrite, done, ovf;
  logic [1:0] ReadReg1, ReadReg2, WriteReg;
  logic [7:0] ReadData1, ReadData2, WriteData, retired;
  logic       ready2, we2, done2, ovf2;
  logic [1:0] rr1_2, rr2_2, wr2, ret2;
  logic [7:0] rd1_2, rd2_2, wd2;
  logic [7:0] rf[4] = '{default: 8'h00};
  logic [7:0] ref_rf[4] = '{default: 8'h00};
  logic       pl_en = 0;
  logic [1:0] pl_a = 0;
  logic [7:0] pl_d = 0;
  typedef struct {logic [1:0] d; logic [7:0] v; logic o; int acc;} exp_t;
  exp_t q[$];
  exp_t cur;
  int e = 0, n_cmp = 0, n_bad = 0, exp_ret = 0;

  reg_seq_ctrl dut (.clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(instr_ready), .ReadReg1(ReadReg1), .ReadReg2(ReadReg2), .ReadData1(ReadData1),
    .ReadData2(ReadData2), .WriteReg(WriteReg), .WriteData(WriteData), .RegWrite(RegWrite),
    .done(done), .ovf(ovf), .retired(retired));
  reg_seq_ctrl #(.CNT_W(2)) dut2 (.clk(clk), .reset(reset), .instr(instr), .instr_valid(instr_valid),
    .instr_ready(ready2), .ReadReg1(rr1_2), .ReadReg2(rr2_2), .ReadData1(rd1_2),
    .ReadData2(rd2_2), .WriteReg(wr2), .WriteData(wd2), .RegWrite(we2),
    .done(done2), .ovf(ovf2), .retired(ret2));

  always #5 clk = ~clk;
  assign ReadData1 = rf[ReadReg1];
  assign ReadData2 = rf[ReadReg2];
  assign rd1_2 = rf[rr1_2];
  assign rd2_2 = rf[rr2_2];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic exp_t predict(input logic [7:0] ins, input int acc);
    exp_t t;
    int a, b, r;
    a = int'($signed(ref_rf[ins[5:4]]));
    b = int'($signed(ref_rf[ins[3:2]]));
    t.d = ins[1:0];
    t.o = 0;
    t.acc = acc;
    r = 0;
    case (ins[7:6])
      2'd0: r = a + b;
      2'd1: r = a - b;
      2'd2: begin r = a + int'($signed(ins[1:0])); t.d = ins[3:2]; end
      default: r = 0;
    endcase
    if (ins[7:6] == 2'd3) t.v = ref_rf[ins[5:4]] & ref_rf[ins[3:2]];
    else begin
      t.v = r[7:0];
      t.o = r > 127 || r < -128;
    end
    return t;
  endfunction

  always @(posedge clk) begin
    if (RegWrite) rf[WriteReg] <= WriteData;
    else if (pl_en) rf[pl_a] <= pl_d;
    if (pl_en) ref_rf[pl_a] = pl_d;
    if (instr_valid && instr_ready && !reset) q.push_back(predict(instr, e));
    e = e + 1;
  end

  always @(negedge clk) if (!reset) begin
    if (RegWrite) begin
      if (q.size() == 0) check("wb_unexpected", 1, 0);
      else begin
        cur = q.pop_front();
        check("wb_reg", WriteReg, cur.d);
        check("wb_data", WriteData, cur.v);
        check("wb_lat", e - cur.acc, 3);
        check("dut2_wb", {we2, wr2, wd2}, {1'b1, cur.d, cur.v});
        ref_rf[cur.d] = cur.v;
      end
    end
    if (done) begin
      exp_ret++;
      check("done_lat", e - cur.acc, 4);
      check("ovf", ovf, cur.o);
      check("retired", retired, exp_ret % 256);
      check("retired_w2", ret2, exp_ret % 4);
      check("dut2_done", {done2, ovf2}, {1'b1, cur.o});
    end
  end

  task automatic preload(input logic [1:0] a, input logic [7:0] d);
    @(negedge clk);
    pl_a = a; pl_d = d; pl_en = 1;
    @(negedge clk);
    pl_en = 0;
  endtask

  task automatic send(input logic [7:0] x);
    int k = 0;
    @(negedge clk);
    while (!instr_ready && k < 20) begin @(negedge clk); k++; end
    if (!instr_ready) check("send_timeout", 0, 1);
    instr = x; instr_valid = 1;
    @(negedge clk);
    instr_valid = 0;
  endtask

  task automatic drain();
    int k = 0;
    @(negedge clk);
    while (!(instr_ready && q.size() == 0 && !RegWrite) && k < 30) begin @(negedge clk); k++; end
    if (k >= 30) check("drain_timeout", 0, 1);
    @(negedge clk);
  endtask

  initial begin
    logic [7:0] lst[4] = '{8'h18, 8'h5B, 8'h86, 8'hC5};
    int idx, k;
    repeat (2) @(negedge clk);
    check("rst_ready", instr_ready, 1);
    check("rst_we", RegWrite, 0);
    check("rst_done_ovf", {done, ovf}, 0);
    check("rst_retired", retired, 0);
    check("rst_rdaddr", {ReadReg1, ReadReg2, WriteReg}, 0);
    check("rst_wdata", WriteData, 0);
    reset = 0;
    @(posedge clk); #1;
    check("post_rst_ready", instr_ready, 1);
    preload(1, 8'h05); preload(2, 8'h03);
    send(8'h18); drain();
    check("ret_after_first", retired, 1);
    check("r0_written", rf[0], 8'h08);
    preload(1, 8'h7F); preload(2, 8'h01);
    send(8'h1B); drain();
    preload(1, 8'h80);
    send(8'h5B); drain();
    preload(0, 8'h00);
    send(8'h86); drain();
    send(8'h85); drain();
    check("addi_r1", rf[1], 8'h01);
    preload(3, 8'hF0);
    send(8'hF6); drain();
    for (int i = 0; i < 10; i++) send(8'($urandom_range(0, 255)));
    drain();
    idx = 0;
    for (k = 0; k < 12; k++) begin
      instr = lst[idx]; instr_valid = 1;
      check("hold_ready", instr_ready, k % 4 == 0);
      check("hold_ready2", ready2, k % 4 == 0);
      if (instr_ready) idx++;
      @(negedge clk);
    end
    instr_valid = 0;
    check("hold_accepted", idx, 3);
    drain();
    reset = 1; @(negedge clk); reset = 0;
    exp_ret = 0; q.delete();
    preload(1, 8'h11); preload(2, 8'h22); preload(3, 8'h55);
    send(8'h1B);
    k = 0;
    do begin @(posedge clk); #1; k++; end while (!RegWrite && k < 10);
    check("abort_saw_wb", RegWrite, 1);
    reset = 1; #1;
    check("abort_we_drop", RegWrite, 0);
    q.delete();
    @(posedge clk); @(negedge clk); reset = 0;
    for (int i = 0; i < 6; i++) begin
      check("abort_no_done", done, 0);
      @(negedge clk);
    end
    check("abort_r3", rf[3], 8'h55);
    check("abort_retired", retired, 0);
    for (int i = 0; i < 5; i++) begin send(8'h86); drain(); end
    check("w2_final", ret2, 1);
    check("queue_empty", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
